// File: rtl/key_command_decoder.sv
// Purpose: turns PS/2 scan bytes into bike direction requests plus start/quit pulses.
// Latency: read pulses 1 cycle after capture; start/quit/pend/last_code update on the edge ending read.
// Backpressure: a byte is acknowledged once; no new capture until scan_ready has been seen low.
module key_command_decoder (
   input  logic       board_clk,
   input  logic       reset,
   input  logic       scan_ready,
   input  logic [7:0] scan_code,
   output logic       read,
   input  logic       step,
   output logic [1:0] p1_dir,
   output logic [1:0] p2_dir,
   output logic       start,
   output logic       quit,
   output logic [7:0] last_code
);

   typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   state_t     state, next_state;
   logic [7:0] code_q;
   logic       ext_q, brk_q;
   logic [1:0] p1_pend, p2_pend;

   logic       is_final;
   logic       dec_p1_vld, dec_p2_vld, dec_start, dec_quit;
   logic [1:0] dec_p1_val, dec_p2_val;

   // Handshake state register.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Handshake next-state and read strobe; WAIT_LOW blocks re-reading the same byte.
   always_comb begin
      next_state = state;
      read       = 1'b0;
      case (state)
         IDLE:     if (scan_ready) next_state = ACK;
         ACK: begin
            read       = 1'b1;
            next_state = WAIT_LOW;
         end
         WAIT_LOW: if (!scan_ready) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Capture the pending byte on the IDLE->ACK transition.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset)                           code_q <= 8'h00;
      else if (state == IDLE && scan_ready) code_q <= scan_code;
   end

   // Decode the captured byte during ACK; releases (brk set) only touch last_code.
   always_comb begin
      is_final   = (state == ACK) && (code_q != CODE_EXT) && (code_q != CODE_BRK);
      dec_p1_vld = 1'b0;
      dec_p2_vld = 1'b0;
      dec_p1_val = DIR_RIGHT;
      dec_p2_val = DIR_RIGHT;
      dec_start  = 1'b0;
      dec_quit   = 1'b0;
      if (is_final && !brk_q) begin
         if (!ext_q) begin
            case (code_q)
               8'h1D: begin dec_p1_vld = 1'b1; dec_p1_val = DIR_UP;    end
               8'h1B: begin dec_p1_vld = 1'b1; dec_p1_val = DIR_DOWN;  end
               8'h1C: begin dec_p1_vld = 1'b1; dec_p1_val = DIR_LEFT;  end
               8'h23: begin dec_p1_vld = 1'b1; dec_p1_val = DIR_RIGHT; end
               8'h29: dec_start = 1'b1;
               8'h76: dec_quit  = 1'b1;
               default: ;
            endcase
         end else begin
            case (code_q)
               8'h75: begin dec_p2_vld = 1'b1; dec_p2_val = DIR_UP;    end
               8'h72: begin dec_p2_vld = 1'b1; dec_p2_val = DIR_DOWN;  end
               8'h6B: begin dec_p2_vld = 1'b1; dec_p2_val = DIR_LEFT;  end
               8'h74: begin dec_p2_vld = 1'b1; dec_p2_val = DIR_RIGHT; end
               default: ;
            endcase
         end
      end
   end

   // Prefix flags accumulate until a final byte, which clears them and updates last_code.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         last_code <= 8'h00;
      end else if (state == ACK) begin
         if (code_q == CODE_EXT)      ext_q <= 1'b1;
         else if (code_q == CODE_BRK) brk_q <= 1'b1;
         else begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            last_code <= code_q;
         end
      end
   end

   // Registered one-cycle command pulses, high in the cycle after read.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         start <= 1'b0;
         quit  <= 1'b0;
      end else begin
         start <= dec_start;
         quit  <= dec_quit;
      end
   end

   // Player 1: start reload wins; step commits the old pend, then a fresh decode overwrites pend.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         p1_dir  <= DIR_RIGHT;
         p1_pend <= DIR_RIGHT;
      end else if (start) begin
         p1_dir  <= DIR_RIGHT;
         p1_pend <= DIR_RIGHT;
      end else begin
         if (step) begin
            if ((p1_dir ^ p1_pend) == 2'b10) p1_pend <= p1_dir;
            else                             p1_dir  <= p1_pend;
         end
         if (dec_p1_vld) p1_pend <= dec_p1_val;
      end
   end

   // Player 2: same commit rules, reloads facing left.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         p2_dir  <= DIR_LEFT;
         p2_pend <= DIR_LEFT;
      end else if (start) begin
         p2_dir  <= DIR_LEFT;
         p2_pend <= DIR_LEFT;
      end else begin
         if (step) begin
            if ((p2_dir ^ p2_pend) == 2'b10) p2_pend <= p2_dir;
            else                             p2_dir  <= p2_pend;
         end
         if (dec_p2_vld) p2_pend <= dec_p2_val;
      end
   end

endmodule

// File: tb/tb_key_command_decoder.sv
// Purpose: directed check of key_command_decoder handshake, decode and commit rules.
// Latency: each byte is fed and observed over a fixed window of negedges.
// Backpressure: the bench drops scan_ready as soon as read is seen.
module tb_key_command_decoder;

   logic       board_clk = 1'b0;
   logic       reset     = 1'b1;
   logic       scan_ready = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       read;
   logic       step = 1'b0;
   logic [1:0] p1_dir, p2_dir;
   logic       start, quit;
   logic [7:0] last_code;

   int checks   = 0;
   int failures = 0;
   int read_cnt = 0, start_cnt = 0, quit_cnt = 0;

   key_command_decoder dut (
      .board_clk (board_clk),
      .reset     (reset),
      .scan_ready(scan_ready),
      .scan_code (scan_code),
      .read      (read),
      .step      (step),
      .p1_dir    (p1_dir),
      .p2_dir    (p2_dir),
      .start     (start),
      .quit      (quit),
      .last_code (last_code)
   );

   always #5 board_clk = ~board_clk;

   // Pulse counters sampled away from the rising edge.
   always @(negedge board_clk) begin
      if (read)  read_cnt++;
      if (start) start_cnt++;
      if (quit)  quit_cnt++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // smode: 0 no step, 1 step on the decode edge, 2 step in the start/quit cycle.
   task automatic send(input logic [7:0] c, input int smode);
      bit got = 0;
      @(negedge board_clk);
      scan_ready = 1'b1;
      scan_code  = c;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge board_clk);
         if (read) got = 1;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL read_timeout: got no read expected read for code %0h", c);
      end
      scan_ready = 1'b0;
      if (smode == 1) step = 1'b1;
      @(negedge board_clk);
      step = (smode == 2);
      @(negedge board_clk);
      step = 1'b0;
      repeat (2) @(negedge board_clk);
   endtask

   task automatic pulse_step();
      @(negedge board_clk);
      step = 1'b1;
      @(negedge board_clk);
      step = 1'b0;
      @(negedge board_clk);
   endtask

   typedef struct {
      logic [7:0] code;
      logic       stp;
      logic [7:0] exp_last;
      logic [1:0] exp_p1;
      logic [1:0] exp_p2;
      int         exp_rd;
      int         exp_st;
      int         exp_qt;
   } vec_t;

   vec_t tv[18];

   initial begin
      int r0, s0, q0;

      tv[0]  = '{8'h1D, 1'b1, 8'h1D, 2'b01, 2'b10, 1, 0, 0};
      tv[1]  = '{8'h29, 1'b0, 8'h29, 2'b00, 2'b10, 1, 1, 0};
      tv[2]  = '{8'h1C, 1'b1, 8'h1C, 2'b00, 2'b10, 1, 0, 0};
      tv[3]  = '{8'h1B, 1'b1, 8'h1B, 2'b11, 2'b10, 1, 0, 0};
      tv[4]  = '{8'hE0, 1'b0, 8'h1B, 2'b11, 2'b10, 1, 0, 0};
      tv[5]  = '{8'h6B, 1'b1, 8'h6B, 2'b11, 2'b10, 1, 0, 0};
      tv[6]  = '{8'hE0, 1'b0, 8'h6B, 2'b11, 2'b10, 1, 0, 0};
      tv[7]  = '{8'hF0, 1'b0, 8'h6B, 2'b11, 2'b10, 1, 0, 0};
      tv[8]  = '{8'h6B, 1'b0, 8'h6B, 2'b11, 2'b10, 1, 0, 0};
      tv[9]  = '{8'hE0, 1'b0, 8'h6B, 2'b11, 2'b10, 1, 0, 0};
      tv[10] = '{8'h75, 1'b1, 8'h75, 2'b11, 2'b01, 1, 0, 0};
      tv[11] = '{8'h74, 1'b1, 8'h74, 2'b11, 2'b01, 1, 0, 0};
      tv[12] = '{8'hE0, 1'b0, 8'h74, 2'b11, 2'b01, 1, 0, 0};
      tv[13] = '{8'h1D, 1'b1, 8'h1D, 2'b11, 2'b01, 1, 0, 0};
      tv[14] = '{8'h76, 1'b0, 8'h76, 2'b11, 2'b01, 1, 0, 1};
      tv[15] = '{8'hF0, 1'b0, 8'h76, 2'b11, 2'b01, 1, 0, 0};
      tv[16] = '{8'h29, 1'b0, 8'h29, 2'b11, 2'b01, 1, 0, 0};
      tv[17] = '{8'h23, 1'b1, 8'h23, 2'b00, 2'b01, 1, 0, 0};

      // Reset state.
      repeat (2) @(negedge board_clk);
      chk("rst_read",  read,      0);
      chk("rst_start", start,     0);
      chk("rst_quit",  quit,      0);
      chk("rst_last",  last_code, 8'h00);
      chk("rst_p1",    p1_dir,    2'b00);
      chk("rst_p2",    p2_dir,    2'b10);
      reset = 1'b0;

      // Table: one byte per row, optional step, then compare.
      for (int i = 0; i < 18; i++) begin
         r0 = read_cnt; s0 = start_cnt; q0 = quit_cnt;
         send(tv[i].code, 0);
         if (tv[i].stp) pulse_step();
         chk($sformatf("v%0d_last", i),  last_code,      tv[i].exp_last);
         chk($sformatf("v%0d_p1", i),    p1_dir,         tv[i].exp_p1);
         chk($sformatf("v%0d_p2", i),    p2_dir,         tv[i].exp_p2);
         chk($sformatf("v%0d_read", i),  read_cnt - r0,  tv[i].exp_rd);
         chk($sformatf("v%0d_start", i), start_cnt - s0, tv[i].exp_st);
         chk($sformatf("v%0d_quit", i),  quit_cnt - q0,  tv[i].exp_qt);
      end

      // Held scan_ready: one read, one start, dirs reload.
      send(8'h1D, 0);
      pulse_step();
      chk("hold_pre_p1", p1_dir, 2'b01);
      r0 = read_cnt; s0 = start_cnt;
      @(negedge board_clk);
      scan_ready = 1'b1;
      scan_code  = 8'h29;
      repeat (20) @(negedge board_clk);
      scan_ready = 1'b0;
      repeat (3) @(negedge board_clk);
      chk("hold_read",  read_cnt - r0,  1);
      chk("hold_start", start_cnt - s0, 1);
      chk("hold_p1",    p1_dir, 2'b00);
      chk("hold_p2",    p2_dir, 2'b10);

      // Start coinciding with step: reload wins over a pending p2 request.
      send(8'hE0, 0);
      send(8'h75, 0);
      send(8'h29, 2);
      chk("startstep_p2", p2_dir, 2'b10);
      pulse_step();
      chk("startstep_p2_after", p2_dir, 2'b10);

      // Reset after F0 with scan_ready already high: 76 must still quit.
      send(8'hF0, 0);
      @(negedge board_clk);
      reset      = 1'b1;
      scan_ready = 1'b1;
      scan_code  = 8'h76;
      @(negedge board_clk);
      chk("midrst_read", read, 0);
      chk("midrst_last", last_code, 8'h00);
      @(negedge board_clk);
      q0 = quit_cnt; r0 = read_cnt;
      reset = 1'b0;
      begin
         bit got = 0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge board_clk);
            if (read) got = 1;
         end
         if (!got) begin
            checks++;
            failures++;
            $display("FAIL midrst_timeout: got no read expected read after reset");
         end
      end
      scan_ready = 1'b0;
      repeat (4) @(negedge board_clk);
      chk("midrst_quit", quit_cnt - q0, 1);
      chk("midrst_rd",   read_cnt - r0, 1);
      chk("midrst_last76", last_code, 8'h76);

      // Step on the decode edge: old pend (01) commits, new pend 00 follows next step.
      send(8'h1D, 0);
      send(8'h23, 1);
      chk("coinc_p1_first", p1_dir, 2'b01);
      pulse_step();
      chk("coinc_p1_next", p1_dir, 2'b00);

      // Dirs hold without step.
      send(8'h1B, 0);
      repeat (3) @(negedge board_clk);
      chk("nostep_p1", p1_dir, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_command_decoder.md
KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

Interface
REQ-001 board_clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clock board_clk.
REQ-003 scan_ready  in  1  level from PS/2 keyboard receiver; a scan byte is pending.
REQ-004 scan_code  in  8  pending scan byte; valid while scan_ready=1.
REQ-005 read  out  1  one-cycle acknowledge pulse to the keyboard receiver.
REQ-006 step  in  1  one-cycle pulse from the game FSM, once per bike move.
REQ-007 p1_dir  out  2  player-1 committed direction: 00 right (+x), 01 up (-y), 10 left (-x), 11 down (+y).
REQ-008 p2_dir  out  2  player-2 committed direction, same encoding.
REQ-009 start  out  1  one-cycle pulse on Space make code.
REQ-010 quit  out  1  one-cycle pulse on Escape make code.
REQ-011 last_code  out  8  most recent non-prefix byte accepted, for SSD display.

Function
REQ-012 The handshake FSM SHALL have states IDLE, ACK, WAIT_LOW.
REQ-013 In IDLE with scan_ready=1, the block SHALL capture scan_code, go to ACK, and assert read for exactly that one cycle.
REQ-014 From ACK the FSM SHALL go to WAIT_LOW; it SHALL return to IDLE only after sampling scan_ready=0, so one byte is never decoded twice.
REQ-015 Byte E0 SHALL set the ext flag. Byte F0 SHALL set the brk flag. Neither SHALL update last_code or produce any other action.
REQ-016 Any other byte SHALL be final. It SHALL update last_code, be decoded with the current flags, and clear ext and brk in the same cycle.
REQ-017 A final byte with brk=1 (key release) SHALL cause no action other than the last_code update.
REQ-018 Non-ext make codes SHALL decode as follows:
- 1D sets p1_pend=01.
- 1B sets p1_pend=11.
- 1C sets p1_pend=10.
- 23 sets p1_pend=00.
- 29 pulses start.
- 76 pulses quit.
REQ-019 Ext make codes SHALL decode as follows:
- 75 sets p2_pend=01.
- 72 sets p2_pend=11.
- 6B sets p2_pend=10.
- 74 sets p2_pend=00.
REQ-020 Unlisted final bytes, and listed bytes carrying the wrong ext flag, SHALL cause no action.
REQ-021 start and quit SHALL go high one cycle after the read pulse and stay high for exactly one cycle.
REQ-022 Each pend register SHALL hold the latest requested direction; a newer make overwrites an older one.
REQ-023 On step=1, each player's pend SHALL be committed to its dir unless (dir XOR pend)=10, which is a 180-degree reversal.
REQ-024 A rejected reversal SHALL leave dir unchanged and reload pend with dir.
REQ-025 If step and a direction decode fall in the same cycle, the commit SHALL use the old pend, and the new value SHALL land in pend.
REQ-026 The start pulse SHALL reload p1_dir and p1_pend to 00, and p2_dir and p2_pend to 10.
REQ-027 If start and step coincide, the reload SHALL take priority over the commit.
REQ-028 Outputs p1_dir and p2_dir SHALL change only on a step or start cycle.

Reset
REQ-029 While reset=1 the block SHALL hold the following values:
- FSM=IDLE, ext=0, brk=0.
- read=0, start=0, quit=0, last_code=00.
- p1_dir=p1_pend=00, p2_dir=p2_pend=10.
REQ-030 Reset asserted mid-sequence (after E0 or F0) SHALL discard the partial sequence; the next byte after release is decoded with clear flags.
REQ-031 After reset releases with scan_ready already 1, the first rising edge SHALL start a normal IDLE capture.

Verification
REQ-032 Feed 1D, then pulse step. Required: read pulses once, last_code=1D, p1_dir 00->01 on the step edge.
REQ-033 From p1_dir=00, feed 1C, then step. Required: p1_dir stays 00 (reversal rejected). Then feed 1B, step. Required: p1_dir=11.
REQ-034 Feed E0 6B, step, then E0 F0 6B. Required: p2_dir stays 10, last_code=6B. Then feed E0 75, step. Required: p2_dir=01, and the release caused no change.
REQ-035 Hold scan_ready=1 for 20 cycles with code 29. Required: exactly one read pulse and one start pulse; dirs reload to 00/10.
REQ-036 Feed F0, then assert reset for 2 cycles, then feed 76. Required: quit pulses once; the F0 prefix is not applied.
REQ-037 Feed 23 with step asserted in the same cycle as the decode. Required: the step commits the old pend, p1_pend=00 afterwards, and the next step gives p1_dir=00.
